// File: rtl/cross_arbiter_pkg.sv
// Shared geofence types and helpers.
//   COORD_W / RES_W : default coordinate width and full-precision cross product width
//   point_t         : packed {x,y} point
//   rr_pick         : round-robin one-hot pick, shared with the inside tester
package cross_arbiter_pkg;
  localparam int COORD_W = 10;
  localparam int RES_W   = 2*COORD_W + 2;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  // Search n requesters starting at ptr+1 with wrap; return one-hot of the first valid.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                                 input int n, input int ptr);
    logic [MAX_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (k <= n && g == '0 && vld[idx[2:0]]) g[idx[2:0]] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/cross_arbiter_if.sv
// Request/response bus of the shared cross-product engine.
//   req_*  : per-requester valid/ready and {x,y} payloads (requester i at slice i)
//   rsp_*  : tagged response with global stall via rsp_ready
//   busy   : engine holds in-flight data
// master = requester side, slave = engine side.
interface cross_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*2*COORD_W-1:0] req_ref;
  logic [NUM_REQ*2*COORD_W-1:0] req_p1;
  logic [NUM_REQ*2*COORD_W-1:0] req_p2;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [2*COORD_W+1:0]         rsp_result;
  logic                         rsp_pos;
  logic                         rsp_zero;
  logic                         busy;

  modport master (
    output req_valid, req_ref, req_p1, req_p2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_pos, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_ref, req_p1, req_p2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_pos, rsp_zero, busy
  );
endinterface

// File: rtl/cross_prod_pipe.sv
// Two-stage cross-product pipe: S1 registers the signed differences, S2 the
// multiply-subtract result with sign/zero flags. Everything advances on adv_i.
//   clk, reset        : clock, async active-high reset
//   adv_i             : pipe advance enable
//   vld_i, id_i       : incoming request valid and tag
//   ref_i, p1_i, p2_i : {x,y} points
//   rsp_*_o           : output registers; busy_o = any stage valid
module cross_prod_pipe #(
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adv_i,
  input  logic                 vld_i,
  input  logic [ID_W-1:0]      id_i,
  input  logic [2*COORD_W-1:0] ref_i,
  input  logic [2*COORD_W-1:0] p1_i,
  input  logic [2*COORD_W-1:0] p2_i,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [2*COORD_W+1:0] rsp_result_o,
  output logic                 rsp_pos_o,
  output logic                 rsp_zero_o,
  output logic                 busy_o
);
  localparam int DW = COORD_W + 1;
  localparam int RW = 2*COORD_W + 2;
  localparam int PW = 2*COORD_W;

  function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic signed [RW-1:0] sx(input logic signed [DW-1:0] d);
    return {{(RW-DW){d[DW-1]}}, d};
  endfunction

  logic signed [DW-1:0] dx1_q, dy1_q, dx2_q, dy2_q;
  logic [ID_W-1:0]      id1_q, rsp_id_q;
  logic                 v1_q, rsp_valid_q, pos_q, zero_q;
  logic signed [RW-1:0] res_d, res_q;

  // |products| < 2^(2*COORD_W) and |difference| <= 2*(2^COORD_W-1)^2, so RW bits never overflow.
  assign res_d = sx(dx1_q) * sx(dy2_q) - sx(dx2_q) * sx(dy1_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      id1_q <= '0;
      dx1_q <= '0; dy1_q <= '0; dx2_q <= '0; dy2_q <= '0;
    end else if (adv_i) begin
      v1_q <= vld_i;
      if (vld_i) begin
        id1_q <= id_i;
        dx1_q <= diff(p1_i[PW-1 -: COORD_W], ref_i[PW-1 -: COORD_W]);
        dy1_q <= diff(p1_i[COORD_W-1:0],     ref_i[COORD_W-1:0]);
        dx2_q <= diff(p2_i[PW-1 -: COORD_W], ref_i[PW-1 -: COORD_W]);
        dy2_q <= diff(p2_i[COORD_W-1:0],     ref_i[COORD_W-1:0]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      res_q       <= '0;
      pos_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv_i) begin
      rsp_valid_q <= v1_q;
      if (v1_q) begin
        rsp_id_q <= id1_q;
        res_q    <= res_d;
        pos_q    <= !res_d[RW-1] && (res_d != '0);
        zero_q   <= (res_d == '0);
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = res_q;
  assign rsp_pos_o    = pos_q;
  assign rsp_zero_o   = zero_q;
  assign busy_o       = v1_q | rsp_valid_q;
endmodule

// File: rtl/cross_arbiter.sv
// Round-robin arbiter in front of the shared cross-product pipe.
//   clk, reset : clock, async active-high reset
//   bus        : cross_arbiter_if slave (requests in, tagged responses out)
// A single global stall: when the output is held, nothing is granted and all stages hold.
module cross_arbiter
  import cross_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
) (
  input  logic            clk,
  input  logic            reset,
  cross_arbiter_if.slave  bus
);
  localparam int PW = 2*COORD_W;

  logic [MAX_REQ-1:0] vld_pad, pick;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    ptr_q, ptr_d, gidx;
  logic               adv, xfer;
  logic [PW-1:0]      ref_m, p1_m, p2_m;

  always_comb begin
    vld_pad = '0;
    vld_pad[NUM_REQ-1:0] = bus.req_valid;
  end

  // Grant depends only on valid and the pointer; gated off while stalled or in reset.
  assign pick  = rr_pick(vld_pad, NUM_REQ, int'(ptr_q));
  assign adv   = !bus.rsp_valid || bus.rsp_ready;
  assign grant = (adv && !reset) ? pick[NUM_REQ-1:0] : '0;
  assign xfer  = |grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = ID_W'(i);
  end

  assign ref_m = bus.req_ref[gidx*PW +: PW];
  assign p1_m  = bus.req_p1[gidx*PW +: PW];
  assign p2_m  = bus.req_p2[gidx*PW +: PW];

  assign ptr_d = xfer ? gidx : ptr_q;

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= ID_W'(NUM_REQ-1);
    else       ptr_q <= ptr_d;
  end

  assign bus.req_ready = grant;

  cross_prod_pipe #(.COORD_W(COORD_W), .ID_W(ID_W)) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .adv_i        (adv),
    .vld_i        (xfer),
    .id_i         (gidx),
    .ref_i        (ref_m),
    .p1_i         (p1_m),
    .p2_i         (p2_m),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_id_o     (bus.rsp_id),
    .rsp_result_o (bus.rsp_result),
    .rsp_pos_o    (bus.rsp_pos),
    .rsp_zero_o   (bus.rsp_zero),
    .busy_o       (bus.busy)
  );
endmodule

// File: tb/tb_cross_arbiter.sv
module tb_cross_arbiter;
  localparam int NR = 2;
  localparam int CW = 10;
  localparam int IW = 3;
  localparam int PW = 2*CW;

  typedef struct { int id; int res; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  exp_t sb[$];

  cross_arbiter_if #(.NUM_REQ(NR), .COORD_W(CW), .ID_W(IW)) bus ();

  cross_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int xprod(int rx, int ry, int ax, int ay, int bx, int by);
    return (ax - rx) * (by - ry) - (bx - rx) * (ay - ry);
  endfunction

  task automatic setp(input int r, input int rx, input int ry, input int ax, input int ay,
                      input int bx, input int by);
    bus.req_ref[r*PW +: PW] = {CW'(rx), CW'(ry)};
    bus.req_p1[r*PW +: PW]  = {CW'(ax), CW'(ay)};
    bus.req_p2[r*PW +: PW]  = {CW'(bx), CW'(by)};
  endtask

  task automatic setrand(input int r);
    setp(r, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
         $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  // Reference model + scoreboard: predicts the round-robin grant from the rule
  // "first valid after the last winner", queues the expected result of every
  // predicted transfer, and pops on every consumed response.
  int   last_g;
  int   gi;
  bit   adv_m;
  logic [NR-1:0] expg;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last_g = NR - 1;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", int'(bus.rsp_id), e.id);
          chk("rsp_result", int'($signed(bus.rsp_result)), e.res);
          chk("rsp_pos", int'(bus.rsp_pos), int'(e.res > 0));
          chk("rsp_zero", int'(bus.rsp_zero), int'(e.res == 0));
        end
      end
      adv_m = !bus.rsp_valid || bus.rsp_ready;
      expg = '0;
      gi = -1;
      if (adv_m) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (last_g + k) % NR;
          if (gi < 0 && bus.req_valid[idx]) gi = idx;
        end
      end
      if (gi >= 0) expg[gi] = 1'b1;
      chk("req_ready", int'(bus.req_ready), int'(expg));
      if (gi >= 0) begin
        e.id  = gi;
        e.res = xprod(int'(bus.req_ref[gi*PW+CW +: CW]), int'(bus.req_ref[gi*PW +: CW]),
                      int'(bus.req_p1[gi*PW+CW +: CW]),  int'(bus.req_p1[gi*PW +: CW]),
                      int'(bus.req_p2[gi*PW+CW +: CW]),  int'(bus.req_p2[gi*PW +: CW]));
        sb.push_back(e);
        last_g = gi;
      end
    end
  end

  // Issue one request on requester r and wait (bounded) for its grant.
  task automatic send(input int r, input int rx, input int ry, input int ax, input int ay,
                      input int bx, input int by);
    int n = 0;
    setp(r, rx, ry, ax, ay, bx, by);
    bus.req_valid[r] = 1'b1;
    @(negedge clk);
    while (!bus.req_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_grant", int'(bus.req_ready[r]), 1);
    @(posedge clk);
    #1 bus.req_valid[r] = 1'b0;
  endtask

  // Single request with directed expected value and latency check.
  task automatic one(input int rx, input int ry, input int ax, input int ay,
                     input int bx, input int by, input int exp_res);
    send(0, rx, ry, ax, ay, bx, by);
    @(negedge clk);
    chk("lat_early", int'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("lat_valid", int'(bus.rsp_valid), 1);
    chk("dir_result", int'($signed(bus.rsp_result)), exp_res);
    chk("dir_id", int'(bus.rsp_id), 0);
    chk("dir_pos", int'(bus.rsp_pos), int'(exp_res > 0));
    chk("dir_zero", int'(bus.rsp_zero), int'(exp_res == 0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW+1:0] held_res;
    int held_id, gidx;

    bus.req_valid = '0;
    bus.req_ref = '0;
    bus.req_p1 = '0;
    bus.req_p2 = '0;
    bus.rsp_ready = 1'b1;
    setrand(0);
    setrand(1);

    // Reset state, with both requesters asserting valid.
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_result", int'(bus.rsp_result), 0);
    chk("rst_rsp_pos", int'(bus.rsp_pos), 0);
    chk("rst_rsp_zero", int'(bus.rsp_zero), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // Contention from reset: alternating grants, back-to-back responses.
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      gidx = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : -1;
      chk("contend_grant", gidx, c % 2);
      chk("contend_rspv", int'(bus.rsp_valid), int'(c >= 2));
      if (c >= 2) chk("contend_rspid", int'(bus.rsp_id), (c - 2) % 2);
      @(posedge clk);
      #1 setrand(0);
      setrand(1);
    end
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Directed values and extremes.
    one(0, 0, 10, 0, 0, 10, 100);
    one(0, 0, 0, 10, 10, 0, -100);
    one(0, 0, 1023, 0, 0, 1023, 1046529);
    one(0, 0, 0, 1023, 1023, 0, -1046529);
    one(1023, 1023, 0, 1023, 1023, 0, 1046529);
    one(5, 5, 10, 10, 20, 20, 0);

    // Stall with a full pipe.
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    held_res = bus.rsp_result;
    held_id = int'(bus.rsp_id);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_result", int'(bus.rsp_result), int'(held_res));
      chk("stall_id", int'(bus.rsp_id), held_id);
      chk("stall_valid", int'(bus.rsp_valid), 1);
      chk("stall_ready", int'(bus.req_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1 chk("stall_drain", sb.size(), 0);

    // Reset pulse with two results in flight.
    bus.req_valid = 2'b11;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.req_valid = '0;
    chk("pre_rst_busy", int'(bus.busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("midrst_ready", int'(bus.req_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", int'(bus.req_ready), 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < NR; r++) begin
        bus.req_valid[r] = ($urandom_range(0, 3) != 0);
        setrand(r);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("final_drain", sb.size(), 0);
    chk("final_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
